pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Multicycle controller that sequences all PC updates: fetch increment, branches,
//  jumps, jr, rte, and exception entry (EPC save + vector load).
//  Drives the 3-bit PC-source mux select, pc_write and epc_write.
//  Hands all other instructions to the main control via an op_start/op_done handshake.
//  Sits between the instruction register decode fields and the PC/EPC registers.
// PARAMETERS
//  VEC_OPC   8'd254  memory byte address holding the invalid-opcode handler address
//  VEC_OVF   8'd255  memory byte address holding the overflow handler address
//  FUNCT_RTE 6'h13   R-type funct code for return-from-exception
// PORTS
//  clk        in   1  clock; all state changes on rising edge
//  reset      in   1  synchronous, active-high
//  opcode     in   6  IR[31:26]
//  funct      in   6  IR[5:0]
//  alu_zero   in   1  ALU zero flag; valid in EXEC_BR
//  overflow   in   1  ALU overflow; sampled only in the cycle op_done=1
//  mem_ready  in   1  memory read data valid this cycle
//  op_done    in   1  main control has finished the delegated instruction
//  pcsource   out  3  mux select: 000 pc, 001 aluout, 010 alu, 011 rega, 100 extendpc, 101 epc
//  pc_write   out  1  PC load enable
//  epc_write  out  1  EPC load enable (ALU drives PC-4 in that cycle)
//  ir_write   out  1  IR load enable
//  mem_read   out  1  memory read request
//  vec_sel    out  1  memory address from vec_addr instead of PC
//  vec_addr   out  8  VEC_OPC or VEC_OVF
//  op_start   out  1  one-cycle pulse: main control takes over
//  exc_cause  out  2  00 none, 01 invalid opcode, 10 overflow; held until next exception or reset
// BEHAVIOUR
//  States: RST, FETCH, FETCH_INC, DECODE, EXEC_BR, JUMP, JR, RTE, DELEG, EXC_SAVE, EXC_VEC, EXC_LOAD.
//  Outputs are Moore per state; any output not listed below for a state is 0.
//  pcsource is 000 whenever pc_write=0.
//  Reset: next edge -> RST. All outputs 0, exc_cause=00.
//   Reset mid-operation is honoured the same way in any state; no pc_write or epc_write in the reset cycle.
//   Reset wins over every other input.
//  RST -> FETCH unconditionally.
//  FETCH: mem_read=1. Stay while mem_ready=0; -> FETCH_INC when mem_ready=1.
//  FETCH_INC: ir_write=1, pcsource=010, pc_write=1 (PC <= PC+4). -> DECODE.
//  DECODE (ALU computes branch target into aluout). Next state:
//   opcode 02/03 (j/jal) -> JUMP
//   04/05 (beq/bne) -> EXEC_BR
//   00 with funct 08 -> JR
//   00 with FUNCT_RTE -> RTE
//   any other opcode in the legal set {00, 08, 0F, 23, 2B, 20, 28} -> DELEG
//   anything else -> EXC_SAVE with exc_cause=01
//  EXEC_BR: taken if (beq & alu_zero) | (bne & !alu_zero).
//   Taken: pcsource=001, pc_write=1. Not taken: no write. -> FETCH.
//  JUMP: pcsource=100, pc_write=1 -> FETCH.
//  JR: pcsource=011, pc_write=1 -> FETCH.
//  RTE: pcsource=101, pc_write=1 -> FETCH.
//  DELEG: op_start=1 on the entry cycle only; wait for op_done.
//   op_done & overflow -> EXC_SAVE with exc_cause=10.
//   op_done & !overflow -> FETCH.
//   op_done in the entry cycle is legal.
//  EXC_SAVE: epc_write=1 -> EXC_VEC.
//  EXC_VEC: mem_read=1, vec_sel=1, vec_addr by cause. Wait for mem_ready -> EXC_LOAD.
//  EXC_LOAD: vec_sel=1, pcsource=100 (zero-extended vector byte), pc_write=1 -> FETCH.
//  Exceptions inside the handler are not nested; EPC is overwritten.
//  Min latency with mem_ready tied 1: j = 4 cycles FETCH..JUMP; exception entry = 3 cycles after decision.
// TESTING
//  1. Reset held 2 cycles in DELEG -> all outputs 0, state FETCH 2 cycles after release, no pc_write.
//  2. mem_ready low 3 cycles, opcode 02 -> FETCH held 3 cycles; then FETCH_INC pcsource=010, then JUMP pcsource=100, pc_write=1.
//  3. opcode 04: alu_zero=1 -> EXEC_BR pcsource=001, pc_write=1; alu_zero=0 -> pc_write=0; opcode 05 inverse.
//  4. opcode 00, funct 08 -> pcsource=011; funct 13 -> pcsource=101, one pc_write each.
//  5. opcode 3F -> epc_write, then vec_addr=254 while mem_ready, then pc_write with pcsource=100, exc_cause=01.
//  6. opcode 00 add: op_start pulse, op_done=1 with overflow=1 after 2 cycles -> EXC_SAVE, vec_addr=255, exc_cause=10.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle controller for every PC update (fetch increment,
// branches, jumps, jr, rte, exception entry). All other instructions are handed
// to the main control through an op_start / op_done handshake.
//
// Handshake: op_start is a one-cycle pulse on the first cycle of DELEG. The
// main control may raise op_done in that same cycle or any later one; the
// sequencer stays in DELEG until it sees op_done=1 and samples overflow only in
// that cycle. There is no back-pressure on op_start.
//
// Outputs are Moore per state (EXEC_BR additionally looks at alu_zero). While
// reset is high every output is forced to 0, so no PC/EPC write can escape in
// the cycle reset is asserted, whatever state the FSM happens to be in.
module pc_sequencer #(
    parameter logic [7:0] VEC_OPC   = 8'd254,
    parameter logic [7:0] VEC_OVF   = 8'd255,
    parameter logic [5:0] FUNCT_RTE = 6'h13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       overflow,
    input  logic       mem_ready,
    input  logic       op_done,
    output logic [2:0] pcsource,
    output logic       pc_write,
    output logic       epc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       vec_sel,
    output logic [7:0] vec_addr,
    output logic       op_start,
    output logic [1:0] exc_cause,
    output logic [3:0] o_dbg_state
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_FETCH_INC = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC_BR  = 4'd4,
        S_JUMP     = 4'd5,
        S_JR       = 4'd6,
        S_RTE      = 4'd7,
        S_DELEG    = 4'd8,
        S_EXC_SAVE = 4'd9,
        S_EXC_VEC  = 4'd10,
        S_EXC_LOAD = 4'd11
    } state_t;

    localparam logic [2:0] PCS_PC     = 3'b000;
    localparam logic [2:0] PCS_ALUOUT = 3'b001;
    localparam logic [2:0] PCS_ALU    = 3'b010;
    localparam logic [2:0] PCS_REGA   = 3'b011;
    localparam logic [2:0] PCS_EXTPC  = 3'b100;
    localparam logic [2:0] PCS_EPC    = 3'b101;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OPC  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cause;
    logic [1:0] w_cause_next;
    logic       r_in_deleg;     // previous cycle was DELEG: op_start already issued
    logic       w_legal_deleg;
    logic       w_br_taken;

    // Opcodes that the main control executes on our behalf.
    always_comb begin
        w_legal_deleg = 1'b0;
        case (opcode)
            6'h00, 6'h08, 6'h0F, 6'h23, 6'h2B, 6'h20, 6'h28: w_legal_deleg = 1'b1;
            default:                                         w_legal_deleg = 1'b0;
        endcase
    end

    // bne is opcode 05, beq is 04: bit 0 inverts the sense of alu_zero.
    assign w_br_taken = opcode[0] ? !alu_zero : alu_zero;

    // State, exception cause and DELEG entry tracking; reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RST;
            r_cause    <= CAUSE_NONE;
            r_in_deleg <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cause    <= w_cause_next;
            r_in_deleg <= (r_state == S_DELEG);
        end
    end

    // Next-state and Moore outputs; all defaults first, reset forces outputs to 0.
    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        pcsource     = PCS_PC;
        pc_write     = 1'b0;
        epc_write    = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        vec_sel      = 1'b0;
        vec_addr     = 8'd0;
        op_start     = 1'b0;

        case (r_state)
            S_RST: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) w_next = S_FETCH_INC;
            end
            S_FETCH_INC: begin
                ir_write = 1'b1;
                pcsource = PCS_ALU;
                pc_write = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == 6'h02 || opcode == 6'h03) begin
                    w_next = S_JUMP;
                end else if (opcode == 6'h04 || opcode == 6'h05) begin
                    w_next = S_EXEC_BR;
                end else if (opcode == 6'h00 && funct == 6'h08) begin
                    w_next = S_JR;
                end else if (opcode == 6'h00 && funct == FUNCT_RTE) begin
                    w_next = S_RTE;
                end else if (w_legal_deleg) begin
                    w_next = S_DELEG;
                end else begin
                    w_next       = S_EXC_SAVE;
                    w_cause_next = CAUSE_OPC;
                end
            end
            S_EXEC_BR: begin
                if (w_br_taken) begin
                    pcsource = PCS_ALUOUT;
                    pc_write = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_JUMP: begin
                pcsource = PCS_EXTPC;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            S_JR: begin
                pcsource = PCS_REGA;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            S_RTE: begin
                pcsource = PCS_EPC;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            S_DELEG: begin
                op_start = !r_in_deleg;
                if (op_done) begin
                    if (overflow) begin
                        w_next       = S_EXC_SAVE;
                        w_cause_next = CAUSE_OVF;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_EXC_SAVE: begin
                epc_write = 1'b1;
                w_next    = S_EXC_VEC;
            end
            S_EXC_VEC: begin
                mem_read = 1'b1;
                vec_sel  = 1'b1;
                vec_addr = (r_cause == CAUSE_OVF) ? VEC_OVF : VEC_OPC;
                if (mem_ready) w_next = S_EXC_LOAD;
            end
            S_EXC_LOAD: begin
                vec_sel  = 1'b1;
                pcsource = PCS_EXTPC;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_RST;
            end
        endcase

        if (reset) begin
            pcsource  = PCS_PC;
            pc_write  = 1'b0;
            epc_write = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            vec_sel   = 1'b0;
            vec_addr  = 8'd0;
            op_start  = 1'b0;
        end
    end

    assign exc_cause   = reset ? CAUSE_NONE : r_cause;
    assign o_dbg_state = r_state;

endmodule
